// File: rtl/dac_spi_driver.sv
// dac_spi_driver: takes one 12-bit sample per valid/ready handshake and sends it
// to an MCP4921-style DAC as a 16-bit SPI mode-0 frame {CONFIG_BITS, sample},
// MSB first. An optional LDAC_n strobe follows while chip select is high.
module dac_spi_driver #(
   parameter int unsigned CLK_DIV     = 4,
   parameter logic [3:0]  CONFIG_BITS = 4'b0011,
   parameter bit          LDAC_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        dac_ldac_n,
   output logic        busy
);

   localparam int unsigned      DIV_W    = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      CSHI  = 3'd4
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [3:0]        bit_cnt;
   logic [15:0]       shreg;
   logic              div_done;
   logic              accept;
   logic              shift_next;

   assign div_done   = (div_cnt == DIV_LAST);
   assign accept     = (state == IDLE) && sample_valid && sample_ready;
   // a falling sclk edge that still has a following bit to present
   assign shift_next = (state == SHIFT) && div_done && dac_sclk && (bit_cnt != 4'd15);

   // Frame data register: loaded at the handshake, shifted on each falling sclk edge.
   always_ff @(posedge clk) begin
      if (accept)
         shreg <= {CONFIG_BITS, sample};
      else if (shift_next)
         shreg <= {shreg[14:0], 1'b0};
   end

   // Frame sequencer with registered SPI/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         sample_ready <= 1'b0;
         dac_cs_n     <= 1'b1;
         dac_sclk     <= 1'b0;
         dac_mosi     <= 1'b0;
         dac_ldac_n   <= 1'b1;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dac_cs_n   <= 1'b1;
               dac_sclk   <= 1'b0;
               dac_ldac_n <= 1'b1;
               if (accept) begin
                  state        <= SETUP;
                  div_cnt      <= '0;
                  bit_cnt      <= '0;
                  sample_ready <= 1'b0;
                  busy         <= 1'b1;
                  dac_cs_n     <= 1'b0;
                  dac_mosi     <= CONFIG_BITS[3];
               end else begin
                  sample_ready <= 1'b1;
                  busy         <= 1'b0;
               end
            end

            SETUP: begin
               if (div_done) begin
                  state    <= SHIFT;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  dac_sclk <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            SHIFT: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (dac_sclk) begin
                     dac_sclk <= 1'b0;
                     if (bit_cnt == 4'd15) begin
                        // last high phase ends straight into HOLD, no trailing low phase
                        state    <= HOLD;
                        bit_cnt  <= '0;
                        dac_mosi <= 1'b0;
                     end else begin
                        dac_mosi <= shreg[14];
                     end
                  end else begin
                     dac_sclk <= 1'b1;
                     bit_cnt  <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            HOLD: begin
               if (div_done) begin
                  state      <= CSHI;
                  div_cnt    <= '0;
                  bit_cnt    <= '0;
                  dac_cs_n   <= 1'b1;
                  dac_ldac_n <= !LDAC_EN;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            CSHI: begin
               if (div_done) begin
                  state        <= IDLE;
                  div_cnt      <= '0;
                  bit_cnt      <= '0;
                  dac_ldac_n   <= 1'b1;
                  sample_ready <= 1'b1;
                  busy         <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            default: begin
               state        <= IDLE;
               div_cnt      <= '0;
               bit_cnt      <= '0;
               sample_ready <= 1'b0;
               dac_cs_n     <= 1'b1;
               dac_sclk     <= 1'b0;
               dac_mosi     <= 1'b0;
               dac_ldac_n   <= 1'b1;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: two instances (CLK_DIV=4 with LDAC, CLK_DIV=1 without)
// checked every cycle against a frame-timing model derived from cycle arithmetic.
module tb_dac_spi_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  vld = 2'b00;
   logic [11:0] smp0 = '0;
   logic [11:0] smp1 = '0;
   logic [1:0]  rdy, csn, sclk, mosi, ldac, bsy;

   int total = 0;
   int bad   = 0;

   // model state per instance
   bit          inf    [2];
   int          cyc    [2];
   logic [15:0] mframe [2];
   bit          mready [2];
   int          acc    [2];

   // observed-frame bookkeeping per instance
   logic        psclk      [2];
   logic        pcsn       [2];
   logic [15:0] cap        [2];
   int          rises      [2];
   logic [15:0] last_frame [2];
   int          last_rises [2];
   int          csn_low    [2];
   int          ldac_low   [2];

   dac_spi_driver #(.CLK_DIV(4), .CONFIG_BITS(4'b0011), .LDAC_EN(1'b1)) u_d4 (
      .clk(clk), .rst(rst), .sample(smp0), .sample_valid(vld[0]),
      .sample_ready(rdy[0]), .dac_cs_n(csn[0]), .dac_sclk(sclk[0]),
      .dac_mosi(mosi[0]), .dac_ldac_n(ldac[0]), .busy(bsy[0]));

   dac_spi_driver #(.CLK_DIV(1), .CONFIG_BITS(4'b0011), .LDAC_EN(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .sample(smp1), .sample_valid(vld[1]),
      .sample_ready(rdy[1]), .dac_cs_n(csn[1]), .dac_sclk(sclk[1]),
      .dac_mosi(mosi[1]), .dac_ldac_n(ldac[1]), .busy(bsy[1]));

   always #5 clk = ~clk;

   function automatic int dv(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic bit en(int i);
      return (i == 0);
   endfunction

   function automatic logic [11:0] getsmp(int i);
      return (i == 0) ? smp0 : smp1;
   endfunction

   // Expected {ready, busy, cs_n, sclk, mosi, ldac_n} in frame cycle c (1..34D).
   function automatic logic [5:0] expv(bit in_frame, int c, logic [15:0] f, int d,
                                       bit ldac_on, bit rdy_idle);
      logic cs, sc, mo, ld;
      int   ph;
      if (!in_frame) return {rdy_idle, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      cs = (c > 33 * d);
      ld = !((c > 33 * d) && ldac_on);
      sc = 1'b0;
      mo = 1'b0;
      if (c <= d) begin
         mo = f[15];
      end else if (c <= 32 * d) begin
         ph = (c - d - 1) / d;
         sc = (ph % 2 == 0);
         mo = f[15 - (ph + 1) / 2];
      end
      return {1'b0, 1'b1, cs, sc, mo, ld};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         inf[i]    = 1'b0;
         mready[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (inf[i]) begin
               if (cyc[i] == 34 * dv(i)) begin
                  inf[i]    = 1'b0;
                  mready[i] = 1'b1;
               end else begin
                  cyc[i]++;
               end
            end else if (mready[i] && vld[i]) begin
               inf[i]    = 1'b1;
               cyc[i]    = 1;
               mframe[i] = {4'h3, getsmp(i)};
               mready[i] = 1'b0;
               acc[i]++;
            end else begin
               mready[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic compare();
      logic [5:0] e, a;
      for (int i = 0; i < 2; i++) begin
         e = expv(inf[i], cyc[i], mframe[i], dv(i), en(i), mready[i]);
         a = {rdy[i], bsy[i], csn[i], sclk[i], mosi[i], ldac[i]};
         chk($sformatf("outputs[%0d] rdy/bsy/cs/sclk/mosi/ldac cyc=%0d", i, cyc[i]),
             32'(a), 32'(e));
         if (rst) begin
            cap[i]   = '0;
            rises[i] = 0;
         end else begin
            if (inf[i] && cyc[i] == 1) begin
               csn_low[i]  = 0;
               ldac_low[i] = 0;
            end
            if (csn[i] === 1'b0)  csn_low[i]++;
            if (ldac[i] === 1'b0) ldac_low[i]++;
            if (sclk[i] === 1'b1 && psclk[i] === 1'b0) begin
               cap[i] = {cap[i][14:0], mosi[i]};
               rises[i]++;
            end
            if (csn[i] === 1'b1 && pcsn[i] === 1'b0) begin
               last_frame[i] = cap[i];
               last_rises[i] = rises[i];
               chk($sformatf("frame[%0d]", i), 32'(cap[i]), 32'(mframe[i]));
               chk($sformatf("sclk rises[%0d]", i), 32'(rises[i]), 32'd16);
               cap[i]   = '0;
               rises[i] = 0;
            end
         end
         psclk[i] = sclk[i];
         pcsn[i]  = csn[i];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic send(int i, logic [11:0] v);
      int a0;
      int n;
      if (i == 0) smp0 = v; else smp1 = v;
      vld[i] = 1'b1;
      a0 = acc[i];
      n = 0;
      while (acc[i] == a0 && n < 400) begin
         step();
         n++;
      end
      chk($sformatf("accept seen[%0d]", i), 32'(acc[i] != a0), 32'd1);
      vld[i] = 1'b0;
   endtask

   task automatic wait_ready(int i, output int k);
      k = 0;
      while (rdy[i] !== 1'b1 && k < 5000) begin
         step();
         k++;
      end
      chk($sformatf("ready returns[%0d]", i), 32'(rdy[i]), 32'd1);
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, " cs_n"},  32'(csn),  32'h3);
      chk({tag, " sclk"},  32'(sclk), 32'h0);
      chk({tag, " mosi"},  32'(mosi), 32'h0);
      chk({tag, " ldac"},  32'(ldac), 32'h3);
      chk({tag, " ready"}, 32'(rdy),  32'h0);
      chk({tag, " busy"},  32'(bsy),  32'h0);
   endtask

   initial begin
      int k;
      int a0;
      logic [11:0] x0;
      for (int i = 0; i < 2; i++) begin
         inf[i] = 0; cyc[i] = 0; mframe[i] = '0; mready[i] = 0; acc[i] = 0;
         psclk[i] = 0; pcsn[i] = 1; cap[i] = '0; rises[i] = 0;
         last_frame[i] = '0; last_rises[i] = 0; csn_low[i] = 0; ldac_low[i] = 0;
      end

      // power-on reset
      repeat (3) step();
      check_reset_outputs("por");
      rst = 1'b0;
      step();
      chk("ready after release", 32'(rdy), 32'h3);

      // reset asserted mid-clock takes effect immediately
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      model_reset();
      #1 check_reset_outputs("async rst");
      @(negedge clk);
      compare();
      step();
      rst = 1'b0;
      step();
      chk("ready one edge after release", 32'(rdy), 32'h3);

      // single frame, D=4
      send(0, 12'hA5C);
      wait_ready(0, k);
      chk("frame A5C", 32'(last_frame[0]), 32'h3A5C);
      chk("rises A5C", 32'(last_rises[0]), 32'd16);
      chk("cs_n low cycles", 32'(csn_low[0]), 32'd132);
      chk("ldac low cycles", 32'(ldac_low[0]), 32'd4);
      chk("ready latency D4", 32'(k), 32'd136);

      // valid held high across two samples
      send(0, 12'h123);
      smp0 = 12'h456;
      vld[0] = 1'b1;
      a0 = acc[0];
      k = 0;
      while (acc[0] == a0 && k < 400) begin
         step();
         k++;
      end
      vld[0] = 1'b0;
      chk("back-to-back accept cycle", 32'(k), 32'd137);
      chk("frame 123", 32'(last_frame[0]), 32'h3123);
      wait_ready(0, k);
      chk("frame 456", 32'(last_frame[0]), 32'h3456);

      // sample and valid churn while busy
      x0 = 12'($urandom);
      send(0, x0);
      for (int n = 0; n < 100; n++) begin
         smp0   = 12'($urandom);
         vld[0] = 1'($urandom_range(0, 1));
         step();
      end
      vld[0] = 1'b0;
      wait_ready(0, k);
      chk("frame captured at handshake", 32'(last_frame[0]), 32'({4'h3, x0}));

      // reset at cycle 50 of a frame
      send(0, 12'h5E7);
      repeat (49) step();
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      model_reset();
      #1 check_reset_outputs("mid-frame rst");
      chk("no ldac before abort", 32'(ldac_low[0]), 32'd0);
      @(negedge clk);
      compare();
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("ready after mid-frame rst", 32'(rdy), 32'h3);
      send(0, 12'h9B1);
      wait_ready(0, k);
      chk("frame after rst", 32'(last_frame[0]), 32'h39B1);

      // D=1, no LDAC
      send(1, 12'hFFF);
      wait_ready(1, k);
      chk("frame FFF", 32'(last_frame[1]), 32'h3FFF);
      chk("ready latency D1", 32'(k), 32'd34);
      chk("cs_n low cycles D1", 32'(csn_low[1]), 32'd33);
      chk("ldac quiet D1", 32'(ldac_low[1]), 32'd0);
      send(1, 12'h000);
      wait_ready(1, k);
      chk("frame 000", 32'(last_frame[1]), 32'h3000);

      // randomized traffic on both instances
      for (int n = 0; n < 1500; n++) begin
         smp0   = 12'($urandom);
         smp1   = 12'($urandom);
         vld[0] = ($urandom_range(0, 3) == 0);
         vld[1] = ($urandom_range(0, 2) == 0);
         step();
      end
      vld = 2'b00;
      wait_ready(0, k);
      wait_ready(1, k);
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
